// File: rtl/exc_seq.sv
// rtl/exc_seq.sv - exception entry/return sequencer driving CP0 and the PC redirect
// Picks one enabled trap or interrupt per idle cycle, stalls while entering or leaving a handler.
module exc_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter int          MAX_DEPTH  = 6,
  parameter int          DEPTH_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        pc_in,
  input  logic               syscall,
  input  logic               brk,
  input  logic               teq_trap,
  input  logic               eret_in,
  input  logic               ext_intr,
  input  logic [31:0]        status,
  input  logic [31:0]        exc_addr_in,
  output logic               exception,
  output logic [4:0]         cause,
  output logic [31:0]        exc_pc,
  output logic               eret,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               kill,
  output logic               stall,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow
);

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  localparam logic [4:0] CAUSE_INTR = 5'd0;
  localparam logic [4:0] CAUSE_SYS  = 5'd8;
  localparam logic [4:0] CAUSE_BRK  = 5'd9;
  localparam logic [4:0] CAUSE_TEQ  = 5'd13;

  typedef enum logic [2:0] {
    IDLE,
    TAKE,
    VECTOR,
    RET,
    RETV
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cause_q, cause_d;
  logic [31:0]        exc_pc_q, exc_pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               pending_q, pending_d;
  logic               ext_q, ext_d;

  logic ev_sys, ev_brk, ev_teq, ev_intr, ev_any;
  logic take_intr;
  logic kill_c;
  logic unused_status;

  assign unused_status = ^status[31:5];

  assign ev_sys  = instr_valid & syscall  & status[0] & status[1];
  assign ev_brk  = instr_valid & brk      & status[0] & status[2];
  assign ev_teq  = instr_valid & teq_trap & status[0] & status[3];
  // The interrupt borrows a retiring instruction so EPC names a real instruction to replay.
  assign ev_intr = instr_valid & pending_q & status[0] & status[4];
  assign ev_any  = ev_sys | ev_brk | ev_teq | ev_intr;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    exc_pc_d    = exc_pc_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    take_intr   = 1'b0;
    kill_c      = 1'b0;
    exception   = 1'b0;
    eret        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    case (state_q)
      IDLE: begin
        if (instr_valid && eret_in) begin
          state_d = RET;
        end else if (ev_any) begin
          if (depth_q == MAX_D) begin
            overflow_d = 1'b1;
          end else begin
            state_d  = TAKE;
            kill_c   = 1'b1;
            exc_pc_d = pc_in;
            if (ev_sys) begin
              cause_d = CAUSE_SYS;
            end else if (ev_brk) begin
              cause_d = CAUSE_BRK;
            end else if (ev_teq) begin
              cause_d = CAUSE_TEQ;
            end else begin
              cause_d   = CAUSE_INTR;
              take_intr = 1'b1;
            end
          end
        end
      end
      TAKE: begin
        exception = 1'b1;
        depth_d   = depth_q + DEPTH_W'(1);
        state_d   = VECTOR;
      end
      VECTOR: begin
        redirect    = 1'b1;
        redirect_pc = EXC_VECTOR;
        state_d     = IDLE;
      end
      RET: begin
        eret = 1'b1;
        if (depth_q != '0) begin
          depth_d = depth_q - DEPTH_W'(1);
        end
        state_d = RETV;
      end
      RETV: begin
        eret        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = exc_addr_in;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A new edge on the same cycle the old request is taken must survive as a fresh request.
  assign pending_d = (pending_q & ~take_intr) | (ext_intr & ~ext_q);
  assign ext_d     = ext_intr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cause_q    <= 5'd0;
      exc_pc_q   <= 32'h0;
      depth_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      exc_pc_q   <= exc_pc_d;
      depth_q    <= depth_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      ext_q      <= ext_d;
    end
  end

  // kill is combinational from the inputs, so it is gated to stay low while reset is held.
  assign kill     = kill_c & rst;
  assign stall    = (state_q != IDLE);
  assign cause    = cause_q;
  assign exc_pc   = exc_pc_q;
  assign depth    = depth_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_exc_seq.sv
// tb/tb_exc_seq.sv - randomized and directed bench for exc_seq against a timeline model
// The model schedules expected pulses by cycle number rather than tracking FSM states.
module tb_exc_seq;

  localparam logic [31:0] VEC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        syscall = 1'b0;
  logic        brk = 1'b0;
  logic        teq_trap = 1'b0;
  logic        eret_in = 1'b0;
  logic        ext_intr = 1'b0;
  logic [31:0] status = 32'h0;
  logic [31:0] exc_addr_in = 32'h0;
  logic        exception;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic        eret;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        kill;
  logic        stall;
  logic [2:0]  depth;
  logic        overflow;

  exc_seq dut (
    .clk(clk), .rst(rst_n), .instr_valid(instr_valid), .pc_in(pc_in),
    .syscall(syscall), .brk(brk), .teq_trap(teq_trap), .eret_in(eret_in),
    .ext_intr(ext_intr), .status(status), .exc_addr_in(exc_addr_in),
    .exception(exception), .cause(cause), .exc_pc(exc_pc), .eret(eret),
    .redirect(redirect), .redirect_pc(redirect_pc), .kill(kill), .stall(stall),
    .depth(depth), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: future events are recorded as the cycle number at which they must appear.
  int          m_cyc, m_exc_at, m_redir_at, m_eret_from, m_eret_to, m_busy_until;
  int          m_depth_at, m_depth_new, m_depth;
  bit          m_redir_ret, m_overflow, m_pending, m_prev_ext;
  logic [4:0]  m_cause;
  logic [31:0] m_epc;

  bit          e_exc, e_redir, e_eret, e_kill, e_stall, e_ovf;
  logic [4:0]  e_cause;
  logic [31:0] e_epc, e_rpc;
  int          e_depth;
  bit          chk_en = 1'b0;

  function automatic void m_reset();
    m_cyc = 0; m_exc_at = -100; m_redir_at = -100; m_eret_from = -100; m_eret_to = -100;
    m_busy_until = -100; m_depth_at = -100; m_depth_new = 0; m_depth = 0;
    m_redir_ret = 0; m_overflow = 0; m_pending = 0; m_prev_ext = 0;
    m_cause = 5'd0; m_epc = 32'h0;
  endfunction

  task automatic drive(input bit iv, input logic [31:0] pc, input bit sc, input bit br,
                       input bit tq, input bit er, input bit ex,
                       input logic [31:0] st, input logic [31:0] ad);
    int c;
    int code;
    bit took;
    @(posedge clk); #1;
    instr_valid = iv; pc_in = pc; syscall = sc; brk = br; teq_trap = tq;
    eret_in = er; ext_intr = ex; status = st; exc_addr_in = ad;
    c = m_cyc;
    took = 0;
    if (c == m_depth_at) m_depth = m_depth_new;
    e_exc   = (c == m_exc_at);
    e_cause = m_cause;
    e_epc   = m_epc;
    e_redir = (c == m_redir_at);
    e_rpc   = m_redir_ret ? ad : VEC;
    e_eret  = (c >= m_eret_from) && (c <= m_eret_to);
    e_stall = (c <= m_busy_until);
    e_depth = m_depth;
    e_ovf   = m_overflow;
    e_kill  = 0;
    if (!e_stall) begin
      if (iv && er) begin
        m_eret_from = c + 1; m_eret_to = c + 2;
        m_redir_at = c + 2; m_redir_ret = 1; m_busy_until = c + 2;
        m_depth_at = c + 2; m_depth_new = (m_depth > 0) ? m_depth - 1 : 0;
      end else begin
        code = -1;
        if (iv && st[0]) begin
          if (sc && st[1]) code = 8;
          else if (br && st[2]) code = 9;
          else if (tq && st[3]) code = 13;
        end
        if (code < 0 && iv && m_pending && st[0] && st[4]) code = 0;
        if (code >= 0) begin
          if (m_depth == 6) begin
            m_overflow = 1;
          end else begin
            e_kill = 1;
            m_exc_at = c + 1; m_cause = code[4:0]; m_epc = pc;
            m_redir_at = c + 2; m_redir_ret = 0; m_busy_until = c + 2;
            m_depth_at = c + 2; m_depth_new = m_depth + 1;
            if (code == 0) took = 1;
          end
        end
      end
    end
    m_pending = (m_pending && !took) || (ex && !m_prev_ext);
    m_prev_ext = ex;
    m_cyc++;
    chk_en = 1;
  endtask

  task automatic idle(input int n, input logic [31:0] st, input logic [31:0] ad);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 0, 0, 0, 0, 0, st, ad);
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    chk_en = 0; rst_n = 0;
    instr_valid = 0; syscall = 0; brk = 0; teq_trap = 0; eret_in = 0; ext_intr = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_reset();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("exception", exception, e_exc);
      if (e_exc) begin
        chk("cause", cause, e_cause);
        chk("exc_pc", exc_pc, e_epc);
      end
      chk("redirect", redirect, e_redir);
      if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
      chk("eret", eret, e_eret);
      chk("kill", kill, e_kill);
      chk("stall", stall, e_stall);
      chk("depth", depth, e_depth);
      chk("overflow", overflow, e_ovf);
    end
  end

  initial begin
    logic [31:0] rpc, rad, rst_v;
    bit ext_lvl;
    m_reset();
    #12;
    chk("rst_exception", exception, 0);
    chk("rst_cause", cause, 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stall", stall, 0);
    chk("rst_depth", depth, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1;
    m_reset();

    // Syscall entry
    drive(1, 32'h0040_0100, 1, 0, 0, 0, 0, 32'h3, 32'h0);
    sample(); chk("lit_sys_kill", kill, 1);
    idle(1, 32'h3, 32'h0);
    sample(); chk("lit_sys_exc", exception, 1); chk("lit_sys_cause", cause, 8);
    chk("lit_sys_epc", exc_pc, 32'h0040_0100);
    idle(1, 32'h3, 32'h0);
    sample(); chk("lit_sys_redir", redirect, 1); chk("lit_sys_rpc", redirect_pc, 32'h0040_0004);
    idle(1, 32'h3, 32'h0);
    sample(); chk("lit_sys_depth", depth, 1); chk("lit_sys_stall", stall, 0);

    // Disabled break is a no-op
    drive(1, 32'h0040_0200, 0, 1, 0, 0, 0, 32'h1, 32'h0);
    sample(); chk("lit_brk_kill", kill, 0); chk("lit_brk_stall", stall, 0);
    idle(1, 32'h1, 32'h0);
    sample(); chk("lit_brk_exc", exception, 0); chk("lit_brk_depth", depth, 1);

    // ERET return
    drive(1, 32'h0040_0300, 0, 0, 0, 1, 0, 32'h3, 32'h0040_0104);
    sample(); chk("lit_eret_kill", kill, 0);
    idle(1, 32'h3, 32'h0040_0104);
    sample(); chk("lit_eret_n1", eret, 1); chk("lit_eret_noredir", redirect, 0);
    idle(1, 32'h3, 32'h0040_0104);
    sample(); chk("lit_eret_n2", eret, 1); chk("lit_eret_redir", redirect, 1);
    chk("lit_eret_rpc", redirect_pc, 32'h0040_0104);
    idle(1, 32'h3, 32'h0040_0104);
    sample(); chk("lit_eret_depth", depth, 0); chk("lit_eret_off", eret, 0);

    // Interrupt edge arriving during VECTOR is held pending
    drive(1, 32'h0040_0400, 1, 0, 0, 0, 0, 32'h13, 32'h0);
    idle(1, 32'h13, 32'h0);
    drive(0, 32'h0, 0, 0, 0, 0, 1, 32'h11, 32'h0);
    drive(0, 32'h0, 0, 0, 0, 0, 0, 32'h11, 32'h0);
    sample(); chk("lit_intr_wait", kill, 0);
    drive(1, 32'h0040_0500, 0, 0, 0, 0, 0, 32'h11, 32'h0);
    sample(); chk("lit_intr_kill", kill, 1);
    idle(1, 32'h11, 32'h0);
    sample(); chk("lit_intr_cause", cause, 0); chk("lit_intr_epc", exc_pc, 32'h0040_0500);
    idle(2, 32'h11, 32'h0);

    // ERET beats a pending interrupt; interrupt follows
    drive(0, 32'h0, 0, 0, 0, 0, 1, 32'h1, 32'h0);
    drive(0, 32'h0, 0, 0, 0, 0, 0, 32'h1, 32'h0);
    drive(1, 32'h0040_0600, 0, 0, 0, 1, 0, 32'h11, 32'h0040_0700);
    sample(); chk("lit_prio_kill", kill, 0);
    idle(1, 32'h11, 32'h0040_0700);
    sample(); chk("lit_prio_eret", eret, 1); chk("lit_prio_noexc", exception, 0);
    idle(2, 32'h11, 32'h0040_0700);
    drive(1, 32'h0040_0700, 0, 0, 0, 0, 0, 32'h11, 32'h0);
    idle(1, 32'h11, 32'h0);
    sample(); chk("lit_prio_intr", exception, 1); chk("lit_prio_cause", cause, 0);
    idle(2, 32'h11, 32'h0);

    // Nesting limit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h0040_1000 + 32'(i * 4), 1, 0, 0, 0, 0, 32'h3, 32'h0);
      idle(3, 32'h3, 32'h0);
    end
    sample(); chk("lit_depth6", depth, 6);
    drive(1, 32'h0040_2000, 1, 0, 0, 0, 0, 32'h3, 32'h0);
    sample(); chk("lit_ovf_kill", kill, 0);
    idle(1, 32'h3, 32'h0);
    sample(); chk("lit_ovf_exc", exception, 0); chk("lit_ovf_flag", overflow, 1);
    chk("lit_ovf_stall", stall, 0);

    // Randomized traffic
    do_reset();
    ext_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom() & 32'hFFFF_FFFC;
      rad = $urandom() & 32'hFFFF_FFFC;
      rst_v = $urandom();
      rst_v[4:0] = 5'b0;
      for (int b = 0; b < 5; b++) rst_v[b] = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 9) == 0) ext_lvl = ~ext_lvl;
      drive($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, ext_lvl, rst_v, rad);
    end
    idle(3, 32'h1, 32'h0);

    // Reset in the middle of TAKE
    do_reset();
    drive(1, 32'h0040_3000, 1, 0, 0, 0, 0, 32'h3, 32'h0);
    idle(1, 32'h3, 32'h0);
    #2;
    chk_en = 0; rst_n = 0;
    #1;
    chk("mid_rst_exc", exception, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_redir", redirect, 0);
    chk("mid_rst_kill", kill, 0);
    chk("mid_rst_cause", cause, 0);
    chk("mid_rst_epc", exc_pc, 0);
    chk("mid_rst_depth", depth, 0);
    @(posedge clk); #1;
    rst_n = 1;
    m_reset();
    idle(4, 32'h3, 32'h0);
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
